// File: rtl/program_run_ctrl.sv
// program_run_ctrl: holds a single-cycle core in reset, releases it at a start PC, and runs it until currentpc reaches an end PC or a watchdog fires
// Ports: CLK/resetl (async active-low) clock and reset; start/abort run control;
//   start_addr/end_addr program window; core_currentpc/core_result from core;
//   core_resetl/core_startpc to core; busy/done/timeout status; result captured
//   MemtoRegOut; cycle_count RUN cycles used.
// Optional: define PC_TRACE_EN to add last_pc (last sampled RUN PC) and pc_stall (sticky repeated-PC flag).
module program_run_ctrl #(
  parameter int RESET_CYCLES = 2,
  parameter int WDOG_WIDTH = 16,
  parameter int WDOG_LIMIT = 255
) (
  input  logic                  CLK,
  input  logic                  resetl,
  input  logic                  start,
  input  logic                  abort,
  input  logic [63:0]           start_addr,
  input  logic [63:0]           end_addr,
  input  logic [63:0]           core_currentpc,
  input  logic [63:0]           core_result,
  output logic                  core_resetl,
  output logic [63:0]           core_startpc,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic [63:0]           result,
`ifdef PC_TRACE_EN
  output logic [63:0]           last_pc,
  output logic                  pc_stall,
`endif
  output logic [WDOG_WIDTH-1:0] cycle_count
);
  localparam int HW = RESET_CYCLES > 1 ? $clog2(RESET_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, HOLD, RUN} state_t;
  state_t state, state_d;
  logic [HW-1:0] hold_cnt, hold_cnt_d;
  logic [63:0] end_reg, end_reg_d, core_startpc_d, result_d;
  logic core_resetl_d, done_d, timeout_d;
  logic [WDOG_WIDTH-1:0] cycle_count_d, cnt_inc;
  always_comb begin
    state_d = state;
    hold_cnt_d = hold_cnt;
    end_reg_d = end_reg;
    core_startpc_d = core_startpc;
    result_d = result;
    core_resetl_d = core_resetl;
    done_d = done;
    timeout_d = timeout;
    cycle_count_d = cycle_count;
    cnt_inc = cycle_count + 1'b1;
    unique case (state)
      IDLE: begin
        core_resetl_d = 1'b0;
        if (start) begin
          core_startpc_d = start_addr;
          end_reg_d = end_addr;
          done_d = 1'b0;
          timeout_d = 1'b0;
          cycle_count_d = '0;
          hold_cnt_d = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (abort) state_d = IDLE;
        else if (hold_cnt == HW'(RESET_CYCLES - 1)) begin
          core_resetl_d = 1'b1;
          state_d = RUN;
        end else hold_cnt_d = hold_cnt + 1'b1;
      end
      RUN: begin
        // abort outranks PC match, which outranks the watchdog
        if (abort) begin
          core_resetl_d = 1'b0;
          state_d = IDLE;
        end else if (core_currentpc >= end_reg) begin
          result_d = core_result;
          done_d = 1'b1;
          core_resetl_d = 1'b0;
          state_d = IDLE;
        end else begin
          cycle_count_d = cnt_inc;
          if (cnt_inc == WDOG_WIDTH'(WDOG_LIMIT)) begin
            timeout_d = 1'b1;
            core_resetl_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state <= IDLE;
      hold_cnt <= '0;
      end_reg <= '0;
      core_startpc <= '0;
      result <= '0;
      core_resetl <= 1'b0;
      done <= 1'b0;
      timeout <= 1'b0;
      cycle_count <= '0;
      busy <= 1'b0;
    end else begin
      state <= state_d;
      hold_cnt <= hold_cnt_d;
      end_reg <= end_reg_d;
      core_startpc <= core_startpc_d;
      result <= result_d;
      core_resetl <= core_resetl_d;
      done <= done_d;
      timeout <= timeout_d;
      cycle_count <= cycle_count_d;
      busy <= state_d != IDLE;
    end
  end
`ifdef PC_TRACE_EN
  // cycle_count is zero only on the first RUN edge, so it gates out the stale last_pc compare
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      last_pc <= '0;
      pc_stall <= 1'b0;
    end else if (state == IDLE && start) pc_stall <= 1'b0;
    else if (state == RUN) begin
      last_pc <= core_currentpc;
      if (cycle_count != '0 && core_currentpc == last_pc) pc_stall <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_program_run_ctrl.sv
// tb_program_run_ctrl: self-checking bench for program_run_ctrl with a PC+4 core model
module tb_program_run_ctrl;
  localparam int RC = 2;
  localparam int L = 255;
  localparam int NO_AB = -1000;
  logic CLK = 1'b0, resetl = 1'b0, start = 1'b0, abort = 1'b0;
  logic [63:0] start_addr = '0, end_addr = '0;
  logic [63:0] core_currentpc, core_result, core_startpc, result;
  logic core_resetl, busy, done, timeout;
  logic [15:0] cycle_count;
`ifdef PC_TRACE_EN
  logic [63:0] last_pc;
  logic pc_stall;
`endif
  int n_chk = 0, n_fail = 0;
  logic [63:0] pc = '0, res_pc = '1, res_val = '0, prev_result = '0;
  bit stuck = 1'b0;

  typedef struct {
    logic [63:0] s, e, rpc, rval;
    bit stk;
    int ab, ms;
    bit d, t;
    int cnt;
    logic [63:0] res;
    int bc;
  } vec_t;
  typedef struct {bit d, t; int cnt; logic [63:0] res; int bc;} exp_t;

  function automatic logic [63:0] fmix(input logic [63:0] x);
    return (x * 64'h9E3779B97F4A7C15) ^ 64'h0123_4567_0F0F_F0F0;
  endfunction

  always #5 CLK = ~CLK;

  program_run_ctrl #(.RESET_CYCLES(RC), .WDOG_WIDTH(16), .WDOG_LIMIT(L)) dut (
    .CLK(CLK), .resetl(resetl), .start(start), .abort(abort),
    .start_addr(start_addr), .end_addr(end_addr),
    .core_currentpc(core_currentpc), .core_result(core_result),
    .core_resetl(core_resetl), .core_startpc(core_startpc),
    .busy(busy), .done(done), .timeout(timeout), .result(result),
`ifdef PC_TRACE_EN
    .last_pc(last_pc), .pc_stall(pc_stall),
`endif
    .cycle_count(cycle_count)
  );

  always @(posedge CLK) pc <= !core_resetl ? core_startpc : (stuck ? pc : pc + 64'd4);
  assign core_currentpc = pc;
  assign core_result = (pc == res_pc) ? res_val : fmix(pc);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Outcome of one run from the window arithmetic: PC after i RUN cycles is s+4*i.
  function automatic exp_t model(input logic [63:0] s, e, input bit stk, input int ab, input logic [63:0] prev);
    exp_t r;
    logic [63:0] hit, fin;
    hit = (s >= e) ? 64'd0 : stk ? '1 : (e - s + 64'd3) / 64'd4;
    fin = (hit < 64'(L - 1)) ? hit : 64'(L - 1);
    r.d = 1'b0;
    r.t = 1'b0;
    r.res = prev;
    if (ab != NO_AB && (ab < 0 || 64'(ab) <= fin)) begin
      r.cnt = ab < 0 ? 0 : ab;
      r.bc = RC + ab + 1;
    end else if (hit <= 64'(L - 1)) begin
      r.d = 1'b1;
      r.cnt = int'(hit);
      r.res = fmix(s + 64'd4 * hit);
      r.bc = RC + int'(hit) + 1;
    end else begin
      r.t = 1'b1;
      r.cnt = L;
      r.bc = RC + L;
    end
    return r;
  endfunction

  // ab: RUN-cycle index where abort is sampled (-1 = last HOLD edge); ms: busy edge where a stray start is sampled
  task automatic run(input logic [63:0] s, e, input bit stk, input int ab, ms, output int bc, output int rs_bad);
    int n;
    @(negedge CLK);
    start_addr = s;
    end_addr = e;
    stuck = stk;
    start = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b0;
    n = 0;
    rs_bad = 0;
    fork
      begin
        if (ab != NO_AB) begin
          repeat (2 + ab) @(posedge CLK);
          @(negedge CLK);
          abort = 1'b1;
          @(negedge CLK);
          abort = 1'b0;
        end
      end
      begin
        if (ms > 0) begin
          repeat (ms - 1) @(negedge CLK);
          start = 1'b1;
          start_addr = ~s;
          end_addr = '0;
          @(negedge CLK);
          start = 1'b0;
          start_addr = s;
          end_addr = e;
        end
      end
      begin
        while (busy === 1'b1 && n < 600) begin
          n++;
          if (core_resetl !== (n > RC)) rs_bad++;
          @(negedge CLK);
        end
      end
    join
    bc = n;
  endtask

  task automatic check_run(input string tag, input logic [63:0] s, input exp_t x, input int bc, rs_bad);
    chk({tag, " busy_cycles"}, 64'(bc), 64'(x.bc));
    chk({tag, " resetl_seq_errs"}, 64'(rs_bad), 64'd0);
    chk({tag, " done"}, 64'(done), 64'(x.d));
    chk({tag, " timeout"}, 64'(timeout), 64'(x.t));
    chk({tag, " cycle_count"}, 64'(cycle_count), 64'(x.cnt));
    chk({tag, " result"}, result, x.res);
    chk({tag, " core_startpc"}, core_startpc, s);
    chk({tag, " idle_resetl"}, 64'(core_resetl), 64'd0);
    chk({tag, " idle_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    vec_t tbl[6];
    exp_t x;
    int bc, rs_bad;
    logic [63:0] s, e;
    bit stk;
    int ab, ms;
    tbl[0] = '{64'h0, 64'h30, 64'h30, 64'hF, 1'b0, NO_AB, 6, 1'b1, 1'b0, 12, 64'hF, 15};
    tbl[1] = '{64'h3c, 64'h5c, 64'h5c, 64'h1234_5678_9abc_def0, 1'b0, NO_AB, 0, 1'b1, 1'b0, 8, 64'h1234_5678_9abc_def0, 11};
    tbl[2] = '{64'h10, 64'h30, '1, 64'h0, 1'b1, NO_AB, 100, 1'b0, 1'b1, 255, 64'h1234_5678_9abc_def0, 257};
    tbl[3] = '{64'h40, 64'h30, 64'h40, 64'h55AA, 1'b0, NO_AB, 2, 1'b1, 1'b0, 0, 64'h55AA, 3};
    tbl[4] = '{64'h100, 64'h200, '1, 64'h0, 1'b0, 5, 0, 1'b0, 1'b0, 5, 64'h55AA, 8};
    tbl[5] = '{64'h0, 64'h30, '1, 64'h0, 1'b0, -1, 0, 1'b0, 1'b0, 0, 64'h55AA, 2};
    repeat (2) @(negedge CLK);
    chk("rst core_resetl", 64'(core_resetl), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done_timeout", {62'd0, done, timeout}, 64'd0);
    chk("rst result", result, 64'd0);
    chk("rst cycle_count", 64'(cycle_count), 64'd0);
    chk("rst core_startpc", core_startpc, 64'd0);
    resetl = 1'b1;
    foreach (tbl[i]) begin
      res_pc = tbl[i].rpc;
      res_val = tbl[i].rval;
      run(tbl[i].s, tbl[i].e, tbl[i].stk, tbl[i].ab, tbl[i].ms, bc, rs_bad);
      x = '{tbl[i].d, tbl[i].t, tbl[i].cnt, tbl[i].res, tbl[i].bc};
      check_run($sformatf("vec%0d", i), tbl[i].s, x, bc, rs_bad);
`ifdef PC_TRACE_EN
      if (i == 2) begin
        chk("trace pc_stall", 64'(pc_stall), 64'd1);
        chk("trace last_pc", last_pc, 64'h10);
      end
`endif
    end
    prev_result = 64'h55AA;
    res_pc = '1;
    // asynchronous reset between clock edges while RUN is in progress
    @(negedge CLK);
    start_addr = 64'h200;
    end_addr = 64'h400;
    stuck = 1'b0;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (8) @(negedge CLK);
    chk("pre_rst busy", 64'(busy), 64'd1);
    #2 resetl = 1'b0;
    #1;
    chk("arst core_resetl", 64'(core_resetl), 64'd0);
    chk("arst busy", 64'(busy), 64'd0);
    chk("arst done_timeout", {62'd0, done, timeout}, 64'd0);
    chk("arst result", result, 64'd0);
    chk("arst cycle_count", 64'(cycle_count), 64'd0);
    chk("arst core_startpc", core_startpc, 64'd0);
    @(negedge CLK);
    resetl = 1'b1;
    prev_result = '0;
    run(64'h0, 64'h30, 1'b0, NO_AB, 0, bc, rs_bad);
    x = model(64'h0, 64'h30, 1'b0, NO_AB, prev_result);
    check_run("post_rst", 64'h0, x, bc, rs_bad);
    prev_result = x.res;
    for (int k = 0; k < 40; k++) begin
      s = {2'b01, 30'($urandom), 32'($urandom)};
      e = ($urandom_range(0, 5) == 0) ? s - 64'($urandom_range(0, 50)) : s + 64'($urandom_range(0, 1100));
      stk = $urandom_range(0, 7) == 0;
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) - 1 : NO_AB;
      x = model(s, e, stk, ab, prev_result);
      ms = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, x.bc)) : 0;
      run(s, e, stk, ab, ms, bc, rs_bad);
      check_run($sformatf("rnd%0d", k), s, x, bc, rs_bad);
      prev_result = x.res;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
